pipelined_cla_adder: RTL
========================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the team's 8-bit carry-lookahead adder.
- Splits a WIDTH-bit add/subtract into STAGES equal chunks. Each chunk is a carry-lookahead adder, and carries ripple between pipeline registers.
- A valid/ready handshake on both sides allows full throughput with backpressure.
- Sits in the datapath as a throughput-oriented arithmetic unit and emits carry/borrow, signed overflow and zero flags.

Parameters:
- WIDTH, 32, operand and sum width in bits. WIDTH % STAGES must be 0; WIDTH >= 2.
- STAGES, 4, pipeline depth and chunk count. STAGES >= 1; chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry-in (add mode) or borrow-in (sub mode).
- sub  input  1  0 = a+b+carry_in; 1 = a-b-carry_in.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- carry_out  output  1  add: carry out of the MSB; sub: borrow (1 when a < b + carry_in, unsigned).
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear; out_valid=0, sum=0, carry_out=0, overflow=0, zero=0. Operand/skew registers need not reset. in_ready=1 during and after reset.
- Global advance enable: adv = !out_valid | out_ready. in_ready = adv (combinational; no combinational path from in_valid to in_ready).
- A beat is accepted when in_valid & in_ready. When adv=0, every pipeline register (data and valid) holds.
- Operand conditioning at acceptance:
  - bx = sub ? ~b : b
  - c0 = sub ? ~carry_in : carry_in
- Stage k (0..STAGES-1) computes chunk k [k*CW +: CW] with generate/propagate lookahead: p = a^bx, g = a&bx, c[i+1] = g[i] | p[i]&c[i], s = p^c. Its carry-in is the registered carry from stage k-1 (c0 for k=0).
- Operand skew: chunk k's operands travel through k delay registers so that they arrive with the carry. Completed sum chunks are deskewed so that the whole sum emerges aligned.
- Latency: exactly STAGES cycles from acceptance to out_valid with no stall. STAGES=1 gives a single registered adder.
- Throughput: one beat per cycle while out_ready=1. Order is preserved; no beat is dropped or duplicated.
- Flags are registered with the final stage:
  - carry_out = sub ? ~cMSB : cMSB
  - overflow = cMSB ^ c(into MSB)
  - zero = (sum == 0)
- Bubbles (in_valid=0 while adv=1) propagate as invalid stages. Output data registers may hold stale values when out_valid=0.
- Simultaneous accept and output: legal in the same cycle when out_ready=1.
- Wrap-around: the sum is modulo 2^WIDTH; only carry_out and overflow report the excess.
- Reset mid-operation: all in-flight beats are discarded; out_valid falls asynchronously; no beat emerges after release.
- Source rule: in_valid and operands must stay stable while in_valid & !in_ready.

Decomposition:
- Package pipelined_cla_pkg:
  - default WIDTH/STAGES localparams.
  - function chunk_w(WIDTH, STAGES).
  - flag-bundle struct {carry_out, overflow, zero}.
- Sub-module cla_chunk (combinational, param CW): inputs a, b, cin; outputs s, cout, c_msb_in (carry into the chunk MSB, used for overflow). It is instantiated STAGES times by generate.
- Top level owns the skew/deskew shift registers, valid chain and handshake.

Test Plan (WIDTH=16, STAGES=2 unless noted):
- Add carry across chunk boundary: a=0x00FF, b=0x0001, cin=0, sub=0 -> 2 cycles later sum=0x0100, carry_out=0, overflow=0, zero=0.
- Full wrap: a=0xFFFF, b=0x0001, add -> sum=0x0000, carry_out=1, zero=1, overflow=0. Also a=0x7FFF, b=0x0001 -> sum=0x8000, overflow=1, carry_out=0.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, carry_out=1, overflow=0. Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, overflow=1.
- Backpressure: 4 back-to-back beats (i+0x1111 for i=0..3), out_ready low for cycles 3-5 -> in_ready low while stalled, outputs held, all 4 results emerge in order, none lost or duplicated. Then out_ready=1 throughout -> one result per cycle.
- Reset mid-flight: 2 beats in the pipe, pulse rst_n low for 1 cycle between edges -> out_valid=0 immediately; no result appears within 2*STAGES cycles after release; the next accepted beat yields the correct sum.
- Parameter sweep: random operands/modes with WIDTH=8/STAGES=1, WIDTH=32/STAGES=4 and WIDTH=64/STAGES=8 against a reference model -> sum and all flags match, latency equals STAGES.

Source files
------------

// File: rtl/pipelined_cla_pkg.sv
// rtl/pipelined_cla_pkg.sv - shared defaults, flag bundle and chunk-width helper
package pipelined_cla_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  typedef struct packed {
    logic carry_out;
    logic overflow;
    logic zero;
  } cla_flags_t;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/cla_chunk.sv
// rtl/cla_chunk.sv - combinational generate/propagate carry-lookahead chunk adder
module cla_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] s,
  output logic          cout,
  output logic          c_msb_in
);

  logic [CW-1:0] p;
  logic [CW-1:0] g;
  logic [CW:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CW; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s        = p ^ c[CW-1:0];
  assign cout     = c[CW];
  // Carry into the top bit; XOR with cout gives signed overflow.
  assign c_msb_in = c[CW-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - STAGES-deep pipelined add/subtract with valid/ready and flags
module pipelined_cla_adder
  import pipelined_cla_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = chunk_w(WIDTH, STAGES);

  logic adv;

  // Per-stage pipeline registers (index k = output of stage k).
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] sub_q;
  logic              carry_q [STAGES];
  logic [WIDTH-1:0]  opa_q   [STAGES];
  logic [WIDTH-1:0]  opb_q   [STAGES];
  logic [WIDTH-1:0]  sum_q   [STAGES];
  logic [WIDTH-1:0]  sum_d   [STAGES];
  cla_flags_t        flags_q;
  cla_flags_t        flags_d;

  // Inputs seen by stage k: the port side for k=0, the previous register otherwise.
  logic [WIDTH-1:0]  st_a    [STAGES];
  logic [WIDTH-1:0]  st_b    [STAGES];
  logic [WIDTH-1:0]  st_sum  [STAGES];
  logic [STAGES-1:0] st_cin;
  logic [STAGES-1:0] st_sub;
  logic [STAGES-1:0] st_valid;

  logic [CW-1:0]     ch_s    [STAGES];
  logic [STAGES-1:0] ch_cout;
  logic              ch_cmsb [STAGES];

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign st_a[k]     = a;
      assign st_b[k]     = sub ? ~b : b;
      assign st_cin[k]   = sub ? ~carry_in : carry_in;
      assign st_sum[k]   = '0;
      assign st_sub[k]   = sub;
      assign st_valid[k] = in_valid;
    end else begin : g_body
      assign st_a[k]     = opa_q[k-1];
      assign st_b[k]     = opb_q[k-1];
      assign st_cin[k]   = carry_q[k-1];
      assign st_sum[k]   = sum_q[k-1];
      assign st_sub[k]   = sub_q[k-1];
      assign st_valid[k] = valid_q[k-1];
    end

    cla_chunk #(
      .CW(CW)
    ) u_chunk (
      .a        (st_a[k][k*CW +: CW]),
      .b        (st_b[k][k*CW +: CW]),
      .cin      (st_cin[k]),
      .s        (ch_s[k]),
      .cout     (ch_cout[k]),
      .c_msb_in (ch_cmsb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]              = st_sum[k];
      sum_d[k][k*CW +: CW]  = ch_s[k];
    end
    // Subtraction runs as a + ~b + ~borrow, so the raw carry is an inverted borrow.
    flags_d.carry_out = st_sub[STAGES-1] ? ~ch_cout[STAGES-1] : ch_cout[STAGES-1];
    flags_d.overflow  = ch_cout[STAGES-1] ^ ch_cmsb[STAGES-1];
    flags_d.zero      = (sum_d[STAGES-1] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      flags_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q <= st_valid;
      flags_q <= flags_d;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
      end
    end
  end

  // Operand skew and carry registers carry no control meaning, so they skip reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      sub_q <= st_sub;
      for (int k = 0; k < STAGES; k++) begin
        opa_q[k]   <= st_a[k];
        opb_q[k]   <= st_b[k];
        carry_q[k] <= ch_cout[k];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign carry_out = flags_q.carry_out;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;

endmodule
